// File: rtl/aes_pkg.sv
// Shared AES-256 datapath types: state width and the word-assembly counter used by
// the plaintext loader, state mux and round datapath.
package aes_pkg;

  localparam int N             = 16;
  localparam int WORDS_PER_BLK = 4;
  localparam int CNT_W         = 3;

  typedef logic [N-1:0][7:0]  state_t;
  typedef logic [CNT_W-1:0]   wcnt_t;

endpackage

// File: rtl/mod_ptxt_loader.sv
// Plaintext loader: packs 32-bit words into a 16-byte state and double-buffers it
// (assembly register + holding register) ahead of the input-select state mux.
module mod_ptxt_loader
  import aes_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output state_t            blk_data,
  output logic [15:0]       blk_cnt
);

  localparam int BPW = WORD_W / 8;

  state_t      asm_reg;
  state_t      asm_next;
  wcnt_t       asm_cnt_reg;
  state_t      blk_data_reg;
  logic        blk_valid_reg;
  logic [15:0] blk_cnt_reg;

  logic accept;
  logic consume;
  logic hold_free;
  logic last_word;
  logic load;

  // in_ready depends only on the assembly count, never on blk_ready.
  assign in_ready  = (asm_cnt_reg < wcnt_t'(WORDS_PER_BLK));
  assign accept    = in_valid && in_ready;
  assign consume   = blk_valid_reg && blk_ready;
  assign hold_free = !blk_valid_reg || blk_ready;
  assign last_word = (accept && (asm_cnt_reg == wcnt_t'(WORDS_PER_BLK - 1))) || !in_ready;
  assign load      = last_word && hold_free;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_byte
      localparam int WI  = gi / BPW;
      localparam int BI  = gi % BPW;
      localparam int LSB = BIG_ENDIAN ? (BPW - 1 - BI) * 8 : BI * 8;
      assign asm_next[gi] = (accept && (asm_cnt_reg == wcnt_t'(WI))) ?
                            in_data[LSB +: 8] : asm_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg     <= '0;
      asm_cnt_reg <= '0;
    end else if (clr) begin
      asm_cnt_reg <= '0;
    end else begin
      if (accept)
        asm_reg <= asm_next;
      if (load)
        asm_cnt_reg <= '0;
      else if (accept)
        asm_cnt_reg <= asm_cnt_reg + wcnt_t'(1);
    end
  end

  // asm_next already contains the word accepted on this edge, so a completing
  // word lands in the holding register without an extra cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_data_reg  <= '0;
      blk_valid_reg <= 1'b0;
      blk_cnt_reg   <= '0;
    end else if (clr) begin
      blk_valid_reg <= 1'b0;
    end else begin
      if (load) begin
        blk_data_reg  <= asm_next;
        blk_valid_reg <= 1'b1;
      end else if (consume) begin
        blk_valid_reg <= 1'b0;
      end
      if (consume)
        blk_cnt_reg <= blk_cnt_reg + 16'd1;
    end
  end

  assign blk_data  = blk_data_reg;
  assign blk_valid = blk_valid_reg;
  assign blk_cnt   = blk_cnt_reg;

endmodule

// File: tb/tb_mod_ptxt_loader.sv
// Directed bench for mod_ptxt_loader: big-endian and little-endian instances share stimulus.
module tb_mod_ptxt_loader;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        blk_ready;

  logic        in_ready_be, blk_valid_be;
  state_t      blk_data_be;
  logic [15:0] blk_cnt_be;
  logic        in_ready_le, blk_valid_le;
  state_t      blk_data_le;
  logic [15:0] blk_cnt_le;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] A_BE = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] A_LE = 128'hCCDDEEFF8899AABB4455667700112233;
  localparam logic [127:0] B_BE = 128'h3C2D1E0FEFCDAB8967452301EFBEADDE;
  localparam logic [127:0] C_BE = 128'h00F0E0D0C0B0A0908070605040302010;

  logic [31:0] wa [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [31:0] wb [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C};
  logic [31:0] wc [4] = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000};

  always #5 clk = ~clk;

  mod_ptxt_loader #(.WORD_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_be), .in_data(in_data),
    .blk_valid(blk_valid_be), .blk_ready(blk_ready),
    .blk_data(blk_data_be), .blk_cnt(blk_cnt_be)
  );

  mod_ptxt_loader #(.WORD_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_le), .in_data(in_data),
    .blk_valid(blk_valid_le), .blk_ready(blk_ready),
    .blk_data(blk_data_le), .blk_cnt(blk_cnt_le)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
    #2;
    n_cmp++; if (in_ready_be !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready_be); end
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL reset_blk_valid: got %b want 0", blk_valid_be); end
    n_cmp++; if (blk_data_be !== '0) begin n_err++; $display("FAIL reset_blk_data: got %h want 0", blk_data_be); end
    n_cmp++; if (blk_cnt_be !== 16'h0) begin n_err++; $display("FAIL reset_blk_cnt: got %h want 0", blk_cnt_be); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    blk_ready = 1'b1;
    put_word(wa[0]); put_word(wa[1]); put_word(wa[2]);
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", blk_valid_be); end
    put_word(wa[3]);
    in_valid = 1'b0;
    n_cmp++; if (blk_valid_be !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", blk_valid_be); end
    n_cmp++; if (blk_data_be[0] !== 8'h00) begin n_err++; $display("FAIL basic_be_b0: got %h want 00", blk_data_be[0]); end
    n_cmp++; if (blk_data_be[7] !== 8'h77) begin n_err++; $display("FAIL basic_be_b7: got %h want 77", blk_data_be[7]); end
    n_cmp++; if (blk_data_be[15] !== 8'hFF) begin n_err++; $display("FAIL basic_be_b15: got %h want ff", blk_data_be[15]); end
    n_cmp++; if (blk_data_be !== A_BE) begin n_err++; $display("FAIL basic_be_block: got %h want %h", blk_data_be, A_BE); end
    n_cmp++; if (blk_data_le[0] !== 8'h33) begin n_err++; $display("FAIL basic_le_b0: got %h want 33", blk_data_le[0]); end
    n_cmp++; if (blk_data_le[3] !== 8'h00) begin n_err++; $display("FAIL basic_le_b3: got %h want 00", blk_data_le[3]); end
    n_cmp++; if (blk_data_le[15] !== 8'hCC) begin n_err++; $display("FAIL basic_le_b15: got %h want cc", blk_data_le[15]); end
    n_cmp++; if (blk_data_le !== A_LE) begin n_err++; $display("FAIL basic_le_block: got %h want %h", blk_data_le, A_LE); end
    n_cmp++; if (in_ready_be !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready_be); end
    step();
    n_cmp++; if (blk_cnt_be !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %h want 1", blk_cnt_be); end
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %b want 0", blk_valid_be); end
    blk_ready = 1'b0;
    $display("test_basic done");
  endtask

  task automatic test_stall();
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_word(wa[i]);
    put_word(wb[0]); put_word(wb[1]);
    n_cmp++; if (blk_data_be !== A_BE) begin n_err++; $display("FAIL stall_stable: got %h want %h", blk_data_be, A_BE); end
    put_word(wb[2]); put_word(wb[3]);
    n_cmp++; if (in_ready_be !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready_be); end
    in_data = 32'h55555555;
    step();
    in_valid = 1'b0;
    n_cmp++; if (blk_data_be !== A_BE) begin n_err++; $display("FAIL stall_hold: got %h want %h", blk_data_be, A_BE); end
    n_cmp++; if (blk_valid_be !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", blk_valid_be); end
    blk_ready = 1'b1;
    step();
    n_cmp++; if (blk_valid_be !== 1'b1) begin n_err++; $display("FAIL stall_reload_valid: got %b want 1", blk_valid_be); end
    n_cmp++; if (blk_data_be !== B_BE) begin n_err++; $display("FAIL stall_block2: got %h want %h", blk_data_be, B_BE); end
    n_cmp++; if (in_ready_be !== 1'b1) begin n_err++; $display("FAIL stall_ready_back: got %b want 1", in_ready_be); end
    n_cmp++; if (blk_cnt_be !== 16'd2) begin n_err++; $display("FAIL stall_cnt1: got %h want 2", blk_cnt_be); end
    step();
    n_cmp++; if (blk_cnt_be !== 16'd3) begin n_err++; $display("FAIL stall_cnt2: got %h want 3", blk_cnt_be); end
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %b want 0", blk_valid_be); end
    blk_ready = 1'b0;
    $display("test_stall done");
  endtask

  task automatic test_back_to_back();
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_word(wa[i]);
    for (int i = 0; i < 3; i++) put_word(wc[i]);
    n_cmp++; if (blk_data_be !== A_BE) begin n_err++; $display("FAIL b2b_held: got %h want %h", blk_data_be, A_BE); end
    blk_ready = 1'b1;
    put_word(wc[3]);
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    n_cmp++; if (blk_valid_be !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", blk_valid_be); end
    n_cmp++; if (blk_data_be !== C_BE) begin n_err++; $display("FAIL b2b_data: got %h want %h", blk_data_be, C_BE); end
    n_cmp++; if (blk_cnt_be !== 16'd4) begin n_err++; $display("FAIL b2b_cnt: got %h want 4", blk_cnt_be); end
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    n_cmp++; if (blk_cnt_be !== 16'd5) begin n_err++; $display("FAIL b2b_cnt2: got %h want 5", blk_cnt_be); end
    $display("test_back_to_back done");
  endtask

  task automatic test_clr();
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_word(wa[i]);
    put_word(wb[0]); put_word(wb[1]);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'hAAAAAAAA; blk_ready = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; blk_ready = 1'b0;
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", blk_valid_be); end
    n_cmp++; if (blk_cnt_be !== 16'd5) begin n_err++; $display("FAIL clr_cnt: got %h want 5", blk_cnt_be); end
    n_cmp++; if (blk_data_be !== A_BE) begin n_err++; $display("FAIL clr_data_kept: got %h want %h", blk_data_be, A_BE); end
    put_word(wc[0]); put_word(wc[1]);
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL clr_partial: got %b want 0", blk_valid_be); end
    put_word(wc[2]); put_word(wc[3]);
    in_valid = 1'b0;
    n_cmp++; if (blk_data_be !== C_BE) begin n_err++; $display("FAIL clr_new_block: got %h want %h", blk_data_be, C_BE); end
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    n_cmp++; if (blk_cnt_be !== 16'd6) begin n_err++; $display("FAIL clr_cnt2: got %h want 6", blk_cnt_be); end
    $display("test_clr done");
  endtask

  task automatic test_async_reset();
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_word(wa[i]);
    for (int i = 0; i < 4; i++) put_word(wb[i]);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", blk_valid_be); end
    n_cmp++; if (blk_data_be !== '0) begin n_err++; $display("FAIL arst_data: got %h want 0", blk_data_be); end
    n_cmp++; if (blk_cnt_be !== 16'd0) begin n_err++; $display("FAIL arst_cnt: got %h want 0", blk_cnt_be); end
    n_cmp++; if (in_ready_be !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", in_ready_be); end
    @(negedge clk);
    rst = 1'b0;
    put_word(wb[0]); put_word(wb[1]); put_word(wb[2]);
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL arst_word0: got %b want 0", blk_valid_be); end
    put_word(wb[3]);
    in_valid = 1'b0;
    n_cmp++; if (blk_data_be !== B_BE) begin n_err++; $display("FAIL arst_block: got %h want %h", blk_data_be, B_BE); end
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    n_cmp++; if (blk_cnt_be !== 16'd1) begin n_err++; $display("FAIL arst_cnt2: got %h want 1", blk_cnt_be); end
    $display("test_async_reset done");
  endtask

  task automatic test_wrap();
    force dut_be.blk_cnt_reg = 16'hFFFE;
    step();
    release dut_be.blk_cnt_reg;
    step();
    n_cmp++; if (blk_cnt_be !== 16'hFFFE) begin n_err++; $display("FAIL wrap_preset: got %h want fffe", blk_cnt_be); end
    for (int i = 0; i < 4; i++) put_word(wc[i]);
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    n_cmp++; if (blk_cnt_be !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h want ffff", blk_cnt_be); end
    for (int i = 0; i < 4; i++) put_word(wa[i]);
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    n_cmp++; if (blk_cnt_be !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h want 0000", blk_cnt_be); end
    n_cmp++; if (blk_valid_be !== 1'b0) begin n_err++; $display("FAIL wrap_valid: got %b want 0", blk_valid_be); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
